// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA/CSUM frames from the UART receiver and issues checked register writes.
// Corrupt, stalled or overrun frames are rejected with a one-cycle frame_err and a saturating error count.
module uart_cmd_ctrl #(
    parameter int          CLOCK_FREQ     = 100000000,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    if (TIMEOUT_CYCLES < 2 || CLOCK_FREQ <= 0) begin : g_bad_param
        $error("uart_cmd_ctrl: TIMEOUT_CYCLES must be >= 2 and CLOCK_FREQ > 0");
    end

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_CSUM,
        ISSUE
    } state_t;

    state_t          state_q;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      wr_addr_q;
    logic [7:0]      wr_data_q;
    logic            wr_valid_q;
    logic            frame_err_q;
    logic [7:0]      err_count_q;
    logic            busy_q;

    logic [7:0]      csum;
    logic            expired;
    logic            in_frame;
    logic            err_d;

    assign csum     = addr_q + data_q;
    assign expired  = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CSUM);

    // A byte arriving in the expiry cycle wins over the timeout.
    always_comb begin
        err_d = 1'b0;
        if (in_frame && !rx_valid && expired) begin
            err_d = 1'b1;
        end
        if (state_q == GET_CSUM && rx_valid && rx_data != csum) begin
            err_d = 1'b1;
        end
        if (state_q == ISSUE && rx_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            timer_q     <= '0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= err_d;
            if (err_d && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'h01;
            end

            case (state_q)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_q <= GET_ADDR;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        if (state_q == GET_ADDR) begin
                            addr_q  <= rx_data;
                            state_q <= GET_DATA;
                        end else begin
                            data_q  <= rx_data;
                            state_q <= GET_CSUM;
                        end
                    end else if (expired) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                GET_CSUM: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        if (rx_data == csum) begin
                            state_q    <= ISSUE;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= addr_q;
                            wr_data_q  <= data_q;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (expired) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ISSUE: begin
                    // Overrun bytes are dropped here; only the error path reacts to them.
                    if (wr_ready) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    wr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level reference model checked every cycle, plus directed literal checks.
module tb_uart_cmd_ctrl;

    localparam int TO = 100;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    uart_cmd_ctrl #(
        .CLOCK_FREQ     (100000000),
        .TIMEOUT_CYCLES (TO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .frame_err (frame_err),
        .err_count (err_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bytes, tracks the idle gap, and holds one pending write.
    int  frm [4];
    int  m_n;
    int  m_gap;
    bit  m_pend;
    int  m_waddr;
    int  m_wdata;
    bit  m_err;
    int  m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_gap = 0; m_pend = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_err = 0;
            if (m_pend) begin
                if (rx_valid) m_err = 1;
                if (wr_ready) m_pend = 0;
            end else if (m_n == 0) begin
                if (rx_valid && rx_data == 8'hA5) begin
                    frm[0] = 'hA5; m_n = 1; m_gap = 0;
                end
            end else if (rx_valid) begin
                frm[m_n] = int'(rx_data);
                m_gap = 0;
                if (m_n < 3) begin
                    m_n++;
                end else begin
                    m_n = 0;
                    if (frm[3] == (frm[1] + frm[2]) % 256) begin
                        m_pend = 1; m_waddr = frm[1]; m_wdata = frm[2];
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (m_gap == TO - 1) begin
                m_n = 0; m_gap = 0; m_err = 1;
            end else begin
                m_gap++;
            end
            if (m_err && m_cnt < 255) m_cnt++;
        end
    end

    bit model_on = 0;
    always @(negedge clk) begin
        if (model_on && !rst) begin
            chk("wr_valid", int'(wr_valid), int'(m_pend));
            chk("frame_err", int'(frame_err), int'(m_err));
            chk("err_count", int'(err_count), m_cnt);
            chk("busy", int'(busy), int'(m_n != 0 || m_pend));
            if (m_pend) begin
                chk("wr_addr", int'(wr_addr), m_waddr);
                chk("wr_data", int'(wr_data), m_wdata);
            end
        end
    end

    int hs = 0;
    always @(posedge clk) if (!rst && wr_valid && wr_ready) hs++;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int gap);
        send_byte(s); idle(gap);
        send_byte(a); idle(gap);
        send_byte(d); idle(gap);
        send_byte(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int hv;
        int hs0;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; wr_ready = 1'b1;
        #7;
        chk("reset wr_valid", int'(wr_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset err_count", int'(err_count), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset wr_data", int'(wr_data), 0);
        idle(2);
        rst = 1'b0;
        model_on = 1;
        idle(2);

        // Nominal frame with ready tied high
        wr_ready = 1'b1;
        send_frame(8'hA5, 8'h10, 8'h3C, 8'h4C, 20);
        chk("nominal wr_valid", int'(wr_valid), 1);
        chk("nominal wr_addr", int'(wr_addr), 'h10);
        chk("nominal wr_data", int'(wr_data), 'h3C);
        idle(1);
        chk("nominal wr_valid drop", int'(wr_valid), 0);
        chk("nominal busy", int'(busy), 0);
        chk("nominal err_count", int'(err_count), 0);

        // Backpressure: ready low for 5 cycles after wr_valid rises
        wr_ready = 1'b0;
        hs0 = hs;
        send_frame(8'hA5, 8'h10, 8'h3C, 8'h4C, 3);
        hv = 0;
        for (int i = 0; i < 16; i++) begin
            if (wr_valid) begin
                hv++;
                chk("bp wr_addr stable", int'(wr_addr), 'h10);
                chk("bp wr_data stable", int'(wr_data), 'h3C);
            end
            if (i == 5) wr_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp valid cycles", hv, 6);
        chk("bp handshakes", hs - hs0, 1);

        // Bad checksum then a good frame
        send_frame(8'hA5, 8'h10, 8'h3C, 8'h00, 2);
        chk("badcs frame_err", int'(frame_err), 1);
        chk("badcs wr_valid", int'(wr_valid), 0);
        idle(1);
        chk("badcs single pulse", int'(frame_err), 0);
        chk("badcs err_count", int'(err_count), 1);
        chk("badcs busy", int'(busy), 0);
        send_frame(8'hA5, 8'h20, 8'h01, 8'h21, 2);
        chk("follow wr_valid", int'(wr_valid), 1);
        chk("follow wr_addr", int'(wr_addr), 'h20);
        chk("follow wr_data", int'(wr_data), 'h01);
        idle(2);

        // Garbage bytes then timeout
        do_reset();
        send_byte(8'h00); idle(3);
        send_byte(8'hFF); idle(3);
        send_byte(8'h5A); idle(3);
        chk("garbage err_count", int'(err_count), 0);
        chk("garbage busy", int'(busy), 0);
        send_byte(8'hA5); idle(2);
        send_byte(8'h10);
        cnt = 0;
        while (!frame_err && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout delay", cnt, TO);
        chk("timeout err_count", int'(err_count), 1);
        idle(1);
        chk("timeout busy", int'(busy), 0);

        // Next byte sampled 99 cycles after the previous one: no timeout
        send_byte(8'hA5); idle(2);
        send_byte(8'h10); idle(TO - 3);
        send_byte(8'h3C);
        send_byte(8'h4C);
        chk("edge99 wr_valid", int'(wr_valid), 1);
        chk("edge99 err_count", int'(err_count), 1);
        idle(2);

        // Byte in the expiry cycle itself wins
        send_byte(8'hA5); idle(2);
        send_byte(8'h10); idle(TO - 2);
        send_byte(8'h3C);
        send_byte(8'h4C);
        chk("edge100 wr_valid", int'(wr_valid), 1);
        chk("edge100 err_count", int'(err_count), 1);
        idle(2);

        // Overrun during ISSUE, then reset while issuing
        do_reset();
        wr_ready = 1'b0;
        send_frame(8'hA5, 8'h10, 8'h3C, 8'h4C, 2);
        idle(2);
        send_byte(8'h77);
        chk("overrun frame_err", int'(frame_err), 1);
        chk("overrun err_count", int'(err_count), 1);
        chk("overrun wr_valid", int'(wr_valid), 1);
        chk("overrun wr_data", int'(wr_data), 'h3C);
        chk("overrun wr_addr", int'(wr_addr), 'h10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst wr_valid", int'(wr_valid), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
        idle(2);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            send_frame(8'hA5, 8'h10, 8'h3C, 8'h00, 1);
            chk("sat frame_err", int'(frame_err), 1);
        end
        idle(1);
        chk("sat err_count", int'(err_count), 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller behind the UART receiver.
- Consumes the receiver's byte stream (byte + one-cycle ready pulse) and parses fixed 4-byte frames: SYNC, ADDR, DATA, CSUM.
- Issues validated register writes to the register bank over a valid/ready handshake.
- Rejects corrupt or stalled frames and counts those errors for board-level debug (LEDs / status register).

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz; documentation only, not used in logic.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between bytes inside a frame (10 ms at 100 MHz); must be >= 2.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte; valid only in the cycle rx_valid=1
- rx_valid  input  1  one-cycle pulse per received byte
- wr_addr  output  8  register address of the pending write
- wr_data  output  8  register data of the pending write
- wr_valid  output  1  write request; held until accepted
- wr_ready  input  1  register bank accepts the write when wr_valid & wr_ready
- frame_err  output  1  one-cycle pulse on any frame rejection
- err_count  output  8  saturating count of frame_err pulses
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, wr_addr=0, wr_data=0, wr_valid=0, frame_err=0, err_count=0, timeout counter=0, internal addr/data latches=0.
- All outputs are registered.
- States:
  - IDLE
    - rx_valid with rx_data==SYNC_BYTE -> GET_ADDR, timer cleared.
    - Any other byte is silently ignored: no error, no count.
  - GET_ADDR
    - rx_valid -> latch rx_data as addr, -> GET_DATA, timer cleared.
    - SYNC_BYTE here is taken as an address value; there is no resync.
  - GET_DATA
    - rx_valid -> latch rx_data as data, -> GET_CSUM, timer cleared.
  - GET_CSUM
    - rx_valid with rx_data == (addr + data) mod 256 -> ISSUE.
    - Mismatch -> IDLE with a frame_err pulse.
  - ISSUE
    - wr_valid=1, wr_addr/wr_data driven from the latches.
    - All three held stable until wr_ready=1 is sampled.
    - Handshake completes in the cycle wr_valid & wr_ready; in the next cycle wr_valid=0 and state=IDLE.
- Latency: wr_valid rises on the first clk edge after the cycle in which the valid CSUM rx_valid is sampled. If wr_ready is already high, the write completes in that first ISSUE cycle.
- Timeout:
  - The counter runs only in GET_ADDR, GET_DATA and GET_CSUM.
  - It increments every cycle without rx_valid and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle -> IDLE with a frame_err pulse.
  - A byte arriving in the same cycle as expiry is accepted; the byte wins.
- Overrun: rx_valid during ISSUE drops the byte and pulses frame_err. The state stays ISSUE and wr_valid/wr_addr/wr_data are unchanged. If the write completes in the same cycle, the byte is still dropped and counted.
- frame_err: exactly one cycle per rejection event; it is asserted the cycle after the causing event.
- err_count: +1 per frame_err pulse; saturates at 8'hFF with no wrap.
- busy = (state != IDLE), registered alongside state.
- Reset mid-frame or mid-ISSUE: wr_valid drops immediately (async) and the partial frame is discarded with no error.
- rx_valid is assumed never high for two consecutive cycles; the bench must not drive it that way, and the implementation need not handle it.

Test Plan:
- Nominal frame, wr_ready tied 1:
  - Stimulus: bytes A5,10,3C,4C, spaced 20 cycles.
  - Response: one wr_valid cycle with wr_addr=0x10, wr_data=0x3C, starting 1 cycle after the 4C pulse; busy returns 0; err_count=0.
- Backpressure:
  - Stimulus: same frame, wr_ready low for 5 cycles after wr_valid rises, then high.
  - Response: wr_valid held 6 cycles with addr/data stable; exactly one handshake.
- Bad checksum:
  - Stimulus: A5,10,3C,00.
  - Response: no wr_valid; frame_err pulses once; err_count=1; state IDLE.
  - Follow-up: frame A5,20,01,21 is then accepted as addr 0x20, data 0x01.
- Garbage and timeout, TIMEOUT_CYCLES=100:
  - Stimulus: bytes 00,FF,5A, then A5,10, then silence.
  - Response: leading bytes ignored (err_count 0); frame_err fires 100 cycles after the 10 pulse; err_count=1.
  - Boundary check: with the next byte sent at exactly cycle 99, there is no timeout.
- Overrun and reset:
  - Stimulus: frame with wr_ready=0, then an extra byte 77 during ISSUE.
  - Response: frame_err pulse; err_count+1; wr_data still 0x3C.
  - Then assert rst while in ISSUE: wr_valid=0 in the same cycle, err_count=0, busy=0.
- Saturation:
  - Stimulus: 260 bad-checksum frames.
  - Response: err_count=0xFF; frame_err still pulses on each rejection.
